// File: rtl/mem_sequencer_if.sv
// rtl/mem_sequencer_if.sv - memory bus between the sequencer and instruction/data memory
interface mem_sequencer_if #(
  parameter int AW = 9,
  parameter int DW = 16
);
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_cmd, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_cmd, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_sequencer.sv
// rtl/mem_sequencer.sv - PC/IR/DAR/WDR owner sequencing fetch and data accesses with wait-state timeout
module mem_sequencer #(
  parameter int            AW       = 9,
  parameter int            DW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            MAX_WAIT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_req,
  input  logic                   data_req,
  input  logic                   data_we,
  input  logic [AW-1:0]          data_addr,
  input  logic [DW-1:0]          data_wdata,
  input  logic                   br_take,
  input  logic                   br_rel,
  input  logic [AW-1:0]          br_target,
  input  logic [AW-1:0]          br_off,
  input  logic                   halt,
  mem_sequencer_if.master        mem,
  output logic [AW-1:0]          pc,
  output logic [DW-1:0]          ir,
  output logic [DW-1:0]          data_rdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   halted
);

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DREAD  = 3'd2,
    S_DWRITE = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] pc_q, pc_nxt;
  logic [DW-1:0] ir_q, ir_nxt;
  logic [AW-1:0] dar_q, dar_nxt;
  logic [DW-1:0] wdr_q, wdr_nxt;
  logic [DW-1:0] rdata_q, rdata_nxt;
  logic [7:0]    wait_q, wait_nxt, wait_inc;
  logic          done_q, done_nxt;
  logic          err_q, err_nxt;

  // State and data registers; reset forces the bus idle immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      dar_q   <= '0;
      wdr_q   <= '0;
      rdata_q <= '0;
      wait_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      ir_q    <= ir_nxt;
      dar_q   <= dar_nxt;
      wdr_q   <= wdr_nxt;
      rdata_q <= rdata_nxt;
      wait_q  <= wait_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
    end
  end

  // Next-state: one IDLE action per cycle (halt > branch > fetch > data), busy states wait on mem_ready
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    ir_nxt    = ir_q;
    dar_nxt   = dar_q;
    wdr_nxt   = wdr_q;
    rdata_nxt = rdata_q;
    wait_nxt  = wait_q;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    wait_inc  = wait_q + 8'd1;
    case (state)
      S_IDLE: begin
        if (halt) begin
          state_nxt = S_HALT;
        end else if (br_take) begin
          pc_nxt = br_rel ? (pc_q + br_off) : br_target;
        end else if (fetch_req) begin
          state_nxt = S_FETCH;
          wait_nxt  = '0;
        end else if (data_req) begin
          dar_nxt   = data_addr;
          wdr_nxt   = data_wdata;
          wait_nxt  = '0;
          state_nxt = data_we ? S_DWRITE : S_DREAD;
        end
      end
      S_FETCH, S_DREAD, S_DWRITE: begin
        if (mem.mem_ready) begin
          // completion beats the timeout when both land in the same cycle
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
          if (state == S_FETCH) begin
            ir_nxt = mem.mem_rdata;
            pc_nxt = pc_q + AW'(1);
          end
          if (state == S_DREAD) begin
            rdata_nxt = mem.mem_rdata;
          end
        end else if (wait_inc == WAIT_LIM) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
          wait_nxt  = wait_inc;
        end else begin
          wait_nxt = wait_inc;
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Bus and status outputs decoded from registered state only
  always_comb begin
    mem.mem_cmd   = 2'b00;
    mem.mem_addr  = pc_q;
    mem.mem_wdata = wdr_q;
    busy          = 1'b0;
    halted        = 1'b0;
    case (state)
      S_FETCH: begin
        mem.mem_cmd = 2'b01;
        busy        = 1'b1;
      end
      S_DREAD: begin
        mem.mem_cmd  = 2'b01;
        mem.mem_addr = dar_q;
        busy         = 1'b1;
      end
      S_DWRITE: begin
        mem.mem_cmd  = 2'b10;
        mem.mem_addr = dar_q;
        busy         = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        mem.mem_cmd = 2'b00;
      end
    endcase
  end

  assign pc         = pc_q;
  assign ir         = ir_q;
  assign data_rdata = rdata_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// tb/tb_mem_sequencer.sv - randomized bench for mem_sequencer against a transaction-level model
module tb_mem_sequencer;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int MW = 4;
  localparam logic [AW-1:0] RPC = '0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic fetch_req = 0, data_req = 0, data_we = 0, br_take = 0, br_rel = 0, halt = 0;
  logic [AW-1:0] data_addr = '0, br_target = '0, br_off = '0;
  logic [DW-1:0] data_wdata = '0;
  logic [AW-1:0] pc;
  logic [DW-1:0] ir, data_rdata;
  logic busy, done, err, halted;

  mem_sequencer_if #(.AW(AW), .DW(DW)) mem_if ();

  mem_sequencer #(.AW(AW), .DW(DW), .RESET_PC(RPC), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .data_req(data_req), .data_we(data_we),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .br_take(br_take), .br_rel(br_rel), .br_target(br_target), .br_off(br_off),
    .halt(halt), .mem(mem_if.master),
    .pc(pc), .ir(ir), .data_rdata(data_rdata),
    .busy(busy), .done(done), .err(err), .halted(halted)
  );

  always #5 clk = ~clk;

  // model: architectural registers plus expected bus/status view
  logic [AW-1:0] m_pc = RPC;
  logic [DW-1:0] m_ir = '0, m_rdata = '0, m_wdr = '0;
  logic [1:0]    exp_cmd = 2'b00;
  logic [AW-1:0] exp_addr = RPC;
  logic exp_busy = 0, exp_done = 0, exp_err = 0, exp_halted = 0;
  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    chk("mem_cmd", 32'(mem_if.mem_cmd), 32'(exp_cmd));
    chk("mem_addr", 32'(mem_if.mem_addr), 32'(exp_addr));
    chk("mem_wdata", 32'(mem_if.mem_wdata), 32'(m_wdr));
    chk("pc", 32'(pc), 32'(m_pc));
    chk("ir", 32'(ir), 32'(m_ir));
    chk("data_rdata", 32'(data_rdata), 32'(m_rdata));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    chk("err", 32'(err), 32'(exp_err));
    chk("halted", 32'(halted), 32'(exp_halted));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    exp_done = 0;
    exp_err = 0;
  endtask

  task automatic model_reset();
    m_pc = RPC; m_ir = '0; m_rdata = '0; m_wdr = '0;
    exp_cmd = 2'b00; exp_addr = RPC;
    exp_busy = 0; exp_done = 0; exp_err = 0; exp_halted = 0;
  endtask

  // kind: 0 fetch, 1 read, 2 write; waits >= MW means memory never answers
  task automatic access(input int kind, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int waits, input logic [DW-1:0] rd);
    int k;
    fetch_req = (kind == 0);
    data_req = (kind != 0);
    data_we = (kind == 2);
    data_addr = a;
    data_wdata = wd;
    mem_if.mem_ready = 0;
    k = 0;
    forever begin
      tick();
      fetch_req = 0;
      data_req = 0;
      data_addr = AW'($urandom);
      data_wdata = DW'($urandom);
      if (k == 0 && kind != 0) m_wdr = wd;
      exp_busy = 1;
      exp_cmd = (kind == 2) ? 2'b10 : 2'b01;
      exp_addr = (kind == 0) ? m_pc : a;
      mem_if.mem_ready = (k == waits);
      mem_if.mem_rdata = (k == waits) ? rd : DW'($urandom);
      if (k == waits || k + 1 == MW) break;
      k++;
    end
    tick();
    mem_if.mem_ready = 0;
    exp_busy = 0;
    exp_cmd = 2'b00;
    if (waits < MW) begin
      exp_done = 1;
      if (kind == 0) begin
        m_ir = rd;
        m_pc = m_pc + 1'b1;
      end
      if (kind == 1) m_rdata = rd;
    end else begin
      exp_err = 1;
    end
    exp_addr = m_pc;
  endtask

  task automatic branch(input logic rel, input logic [AW-1:0] tgt, input logic [AW-1:0] off,
                        input logic with_fetch);
    br_take = 1; br_rel = rel; br_target = tgt; br_off = off;
    fetch_req = with_fetch;
    data_req = 1'($urandom);
    data_we = 1'($urandom);
    tick();
    br_take = 0;
    data_req = 0;
    m_pc = rel ? (m_pc + off) : tgt;
    exp_addr = m_pc;
    if (with_fetch) access(0, '0, '0, $urandom_range(0, MW), DW'($urandom));
    else fetch_req = 0;
  endtask

  initial begin
    logic [DW-1:0] ir_hold;
    mem_if.mem_ready = 0;
    mem_if.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset mem_cmd", 32'(mem_if.mem_cmd), 32'd0);
    chk("reset pc", 32'(pc), 32'(RPC));
    reset = 1;

    // zero-wait fetch
    access(0, '0, '0, 0, 16'hD105);
    chk("fetch0 done", 32'(done), 32'd1);
    chk("fetch0 ir", 32'(ir), 32'hD105);
    chk("fetch0 pc", 32'(pc), 32'd1);

    // three wait states
    access(0, '0, '0, 3, 16'h1234);
    chk("fetch3 done", 32'(done), 32'd1);
    chk("fetch3 err", 32'(err), 32'd0);
    chk("fetch3 ir", 32'(ir), 32'h1234);

    // timeout leaves pc and ir alone
    access(0, '0, '0, MW, 16'hFFFF);
    chk("timeout err", 32'(err), 32'd1);
    chk("timeout done", 32'(done), 32'd0);
    chk("timeout pc", 32'(pc), 32'd2);
    chk("timeout ir", 32'(ir), 32'h1234);

    // pc wrap and relative branch
    branch(0, 9'h1FF, '0, 0);
    access(0, '0, '0, 0, 16'h0A0A);
    chk("wrap pc", 32'(pc), 32'd0);
    branch(1, '0, 9'h1FE, 0);
    chk("rel pc", 32'(pc), 32'h1FE);

    // write then read back
    access(2, 9'h140, 16'hBEEF, 1, '0);
    chk("write wdata", 32'(mem_if.mem_wdata), 32'hBEEF);
    access(1, 9'h140, 16'h5555, 0, 16'hBEEF);
    chk("read rdata", 32'(data_rdata), 32'hBEEF);
    chk("read pc", 32'(pc), 32'h1FE);

    // branch with fetch held: fetch runs at the new pc
    branch(0, 9'h033, '0, 1);
    chk("br+fetch pc", 32'(pc), 32'h034);

    // randomized mix
    for (int i = 0; i < 300; i++) begin
      int op;
      op = $urandom_range(0, 6);
      case (op)
        0: access(0, '0, '0, $urandom_range(0, MW), DW'($urandom));
        1: access(1, AW'($urandom), DW'($urandom), $urandom_range(0, MW), DW'($urandom));
        2: access(2, AW'($urandom), DW'($urandom), $urandom_range(0, MW), DW'($urandom));
        3: branch(0, AW'($urandom), AW'($urandom), 0);
        4: branch(1, AW'($urandom), AW'($urandom), 0);
        5: branch(1'($urandom), AW'($urandom), AW'($urandom), 1);
        default: begin
          mem_if.mem_ready = 1'($urandom);
          tick();
          mem_if.mem_ready = 0;
        end
      endcase
    end

    // halt wins over fetch and freezes everything
    ir_hold = m_ir;
    halt = 1;
    fetch_req = 1;
    tick();
    exp_halted = 1;
    chk("halted", 32'(halted), 32'd1);
    for (int i = 0; i < 12; i++) begin
      halt = 1'($urandom); fetch_req = 1'($urandom); data_req = 1'($urandom);
      data_we = 1'($urandom); br_take = 1'($urandom); br_rel = 1'($urandom);
      br_target = AW'($urandom); br_off = AW'($urandom); data_addr = AW'($urandom);
      mem_if.mem_ready = 1'($urandom); mem_if.mem_rdata = DW'($urandom);
      tick();
    end
    chk("halt ir frozen", 32'(ir), 32'(ir_hold));
    chk("halt cmd", 32'(mem_if.mem_cmd), 32'd0);
    halt = 0; fetch_req = 0; data_req = 0; br_take = 0; mem_if.mem_ready = 0;

    // reset out of HALT
    reset = 0;
    model_reset();
    tick();
    reset = 1;
    access(0, '0, '0, 0, 16'h7777);

    // reset in the middle of a write
    data_req = 1; data_we = 1; data_addr = 9'h0AA; data_wdata = 16'hC0DE;
    tick();
    data_req = 0;
    m_wdr = 16'hC0DE;
    exp_busy = 1; exp_cmd = 2'b10; exp_addr = 9'h0AA;
    #1;
    reset = 0;
    #1;
    chk("rst mid cmd", 32'(mem_if.mem_cmd), 32'd0);
    chk("rst mid pc", 32'(pc), 32'(RPC));
    chk("rst mid busy", 32'(busy), 32'd0);
    model_reset();
    tick();
    reset = 1;
    access(1, 9'h011, '0, 2, 16'h4242);
    chk("post-reset read", 32'(data_rdata), 32'h4242);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
